// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and constants for the program-counter stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int unsigned PC_INC = 4;
    localparam int unsigned JIDX_W = 26;
    localparam int unsigned IMM_W  = 16;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEQ  = 2'd0,
        BR   = 2'd1,
        JMP  = 2'd2,
        PEND = 2'd3
    } nxt_sel_t;

endpackage

`default_nettype wire

// File: rtl/pc_next_stage_if.sv
// ============================================================================
// Module      : pc_next_stage_if
// Description : Decision-logic inputs and fetch-side outputs of the PC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_next_stage_if
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic              ins_ready;
    logic              stall;
    logic              halt;
    logic              branch_en;
    logic [IMM_W-1:0]  branch_imm;
    logic              jump_en;
    logic [JIDX_W-1:0] jump_idx;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  pc_plus4;
    logic              pc_valid;
    logic              redirect;

    modport master (
        input  ins_ready, stall, halt, branch_en, branch_imm, jump_en, jump_idx,
        output pc, pc_plus4, pc_valid, redirect
    );

    modport slave (
        output ins_ready, stall, halt, branch_en, branch_imm, jump_en, jump_idx,
        input  pc, pc_plus4, pc_valid, redirect
    );

endinterface

`default_nettype wire

// File: rtl/pc_target_calc.sv
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational sequential, branch and jump targets from pc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_calc
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int INC   = PC_INC
) (
    input  logic [WIDTH-1:0]  i_pc,
    input  logic [IMM_W-1:0]  i_branch_imm,
    input  logic [JIDX_W-1:0] i_jump_idx,
    output logic [WIDTH-1:0]  o_pc_plus4,
    output logic [WIDTH-1:0]  o_br_tgt,
    output logic [WIDTH-1:0]  o_j_tgt
);

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_br_off;

    assign w_pc_plus4 = i_pc + WIDTH'(INC);
    assign w_br_off   = WIDTH'($signed(i_branch_imm)) << 2;
    assign o_br_tgt   = w_pc_plus4 + w_br_off;
    assign o_pc_plus4 = w_pc_plus4;

    // Narrow PCs have no region bits to keep; the index is simply truncated.
    generate
        if (WIDTH >= 32) begin : g_jmp_region
            assign o_j_tgt = {w_pc_plus4[WIDTH-1:28], i_jump_idx, 2'b00};
        end else begin : g_jmp_trunc
            logic [WIDTH+27:0] w_jfull;
            assign w_jfull = {{WIDTH{1'b0}}, i_jump_idx, 2'b00};
            assign o_j_tgt = w_jfull[WIDTH-1:0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/pc_next_stage.sv
// ============================================================================
// Module      : pc_next_stage
// Description : PC register, next-PC selection, one-entry redirect buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_stage
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h80),
    parameter int               INC      = PC_INC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_next_stage_if.master        bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_pc_valid;
    logic             r_redirect;
    logic             r_pend_vld;
    logic [WIDTH-1:0] r_pend_tgt;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_br_tgt;
    logic [WIDTH-1:0] w_j_tgt;
    logic [WIDTH-1:0] w_live_tgt;
    logic [WIDTH-1:0] w_next;
    logic             w_adv;
    logic             w_live;
    nxt_sel_t         w_sel;

    pc_target_calc #(
        .WIDTH (WIDTH),
        .INC   (INC)
    ) u_tgt (
        .i_pc         (r_pc),
        .i_branch_imm (bus.branch_imm),
        .i_jump_idx   (bus.jump_idx),
        .o_pc_plus4   (w_pc_plus4),
        .o_br_tgt     (w_br_tgt),
        .o_j_tgt      (w_j_tgt)
    );

    always_comb begin
        w_adv      = (r_state == RUN) & r_pc_valid & bus.ins_ready & ~bus.stall & ~bus.halt;
        w_live     = bus.jump_en | bus.branch_en;
        w_live_tgt = bus.jump_en ? w_j_tgt : w_br_tgt;
        w_sel      = SEQ;
        if (bus.jump_en)        w_sel = JMP;
        else if (bus.branch_en) w_sel = BR;
        else if (r_pend_vld)    w_sel = PEND;
        case (w_sel)
            JMP:     w_next = w_j_tgt;
            BR:      w_next = w_br_tgt;
            PEND:    w_next = r_pend_tgt;
            default: w_next = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_redirect <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                BOOT: begin
                    r_state    <= RUN;
                    r_pc_valid <= 1'b1;
                end
                RUN: begin
                    // Any advance retires the buffered redirect; a live one supersedes it.
                    if (w_adv) begin
                        r_pc       <= w_next;
                        r_redirect <= (w_sel != SEQ);
                        r_pend_vld <= 1'b0;
                    end else if (w_live) begin
                        r_pend_tgt <= w_live_tgt;
                        r_pend_vld <= 1'b1;
                    end
                    if (bus.halt) begin
                        r_state    <= HALTED;
                        r_pc_valid <= 1'b0;
                    end
                end
                HALTED: begin
                    if (!bus.halt) begin
                        r_state    <= RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_pc_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_plus4 = w_pc_plus4;
    assign bus.pc_valid = r_pc_valid;
    assign bus.redirect = r_redirect;

endmodule

`default_nettype wire
